// File: rtl/adat_sample_reader.sv
// Streams one committed ADAT frame at a time out of the bit-serial circular RAM
// as 24-bit samples (left-justified in 32 bits) over a valid/ready handshake.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// StIdle      | decoder not locked; waiting for has_sync_i
// StWaitFrame | waiting for a committed frame; resyncs and counts drops on overrun
// StRead      | issuing one RAM bit address per cycle, bit 0..23
// StDrain     | capturing the last returned bit and loading the sample outputs
// StOutput    | holding the sample until the consumer accepts it
module adat_sample_reader #(
  parameter int CIRC_BUF_BITS = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       has_sync_i,
  input  logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_i,
  output logic [CIRC_BUF_BITS+7:0]   ram_read_addr_o,
  input  logic                       ram_read_data_i,
  output logic [31:0]                sample_data_o,
  output logic [2:0]                 sample_channel_o,
  output logic                       sample_last_o,
  output logic                       sample_valid_o,
  input  logic                       sample_ready_i,
  output logic [15:0]                dropped_frames_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitFrame,
    StRead,
    StDrain,
    StOutput
  } state_e;

  localparam logic [CIRC_BUF_BITS-1:0] PendEmpty   = '1;
  localparam logic [CIRC_BUF_BITS-1:0] PendOverrun = PendEmpty - CIRC_BUF_BITS'(1);
  localparam logic [4:0]               LastBit     = 5'd23;

  state_e                   state_r;
  logic [CIRC_BUF_BITS-1:0] rd_frame_r;
  logic [2:0]               channel_r;
  logic [4:0]               bit_r;
  logic [23:0]              shift_r;

  logic [CIRC_BUF_BITS-1:0] pending;
  logic                     frame_avail;
  logic                     frame_overrun;
  logic [16:0]              drop_sum;

  // pending == all-ones means the reader is one past the newest committed frame
  assign pending       = last_good_frame_idx_i - rd_frame_r;
  assign frame_avail   = (pending != PendEmpty);
  assign frame_overrun = (pending == PendOverrun);
  assign drop_sum      = {1'b0, dropped_frames_o} + {{(17-CIRC_BUF_BITS){1'b0}}, pending};

  assign ram_read_addr_o = (state_r == StRead) ? {rd_frame_r, channel_r, bit_r} : '0;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r          <= StIdle;
      rd_frame_r       <= '0;
      channel_r        <= '0;
      bit_r            <= '0;
      shift_r          <= '0;
      sample_data_o    <= '0;
      sample_channel_o <= '0;
      sample_last_o    <= 1'b0;
      sample_valid_o   <= 1'b0;
      dropped_frames_o <= '0;
    end else begin
      case (state_r)
        StIdle: begin
          if (has_sync_i) begin
            rd_frame_r <= last_good_frame_idx_i;
            state_r    <= StWaitFrame;
          end
        end

        StWaitFrame: begin
          if (!has_sync_i) begin
            state_r <= StIdle;
          end else if (frame_overrun) begin
            rd_frame_r       <= last_good_frame_idx_i;
            dropped_frames_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
          end else if (frame_avail) begin
            channel_r <= '0;
            bit_r     <= '0;
            state_r   <= StRead;
          end
        end

        StRead: begin
          // RAM data lags the address by one cycle, so nothing arrives on bit 0
          if (bit_r != 5'd0) begin
            shift_r <= {shift_r[22:0], ram_read_data_i};
          end
          if (bit_r == LastBit) begin
            state_r <= StDrain;
          end else begin
            bit_r <= bit_r + 5'd1;
          end
        end

        StDrain: begin
          shift_r          <= {shift_r[22:0], ram_read_data_i};
          sample_data_o    <= {shift_r[22:0], ram_read_data_i, 8'h00};
          sample_channel_o <= channel_r;
          sample_last_o    <= (channel_r == 3'd7);
          sample_valid_o   <= 1'b1;
          state_r          <= StOutput;
        end

        StOutput: begin
          if (sample_valid_o && sample_ready_i) begin
            sample_valid_o <= 1'b0;
            if (channel_r != 3'd7) begin
              channel_r <= channel_r + 3'd1;
              bit_r     <= '0;
              state_r   <= StRead;
            end else begin
              rd_frame_r <= rd_frame_r + CIRC_BUF_BITS'(1);
              state_r    <= StWaitFrame;
            end
          end
        end

        default: state_r <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adat_sample_reader.sv
// Bench for adat_sample_reader: behavioural bit-serial RAM, expected samples
// queued per frame and compared as each handshake completes.
module tb_adat_sample_reader;

  localparam int CB = 3;

  logic            clk_i = 1'b0;
  logic            reset_ni;
  logic            has_sync_i;
  logic [CB-1:0]   last_good_frame_idx_i;
  logic [CB+7:0]   ram_read_addr_o;
  logic            ram_read_data_i;
  logic [31:0]     sample_data_o;
  logic [2:0]      sample_channel_o;
  logic            sample_last_o;
  logic            sample_valid_o;
  logic            sample_ready_i;
  logic [15:0]     dropped_frames_o;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  ch;
    logic        last;
  } exp_t;

  exp_t sb[$];
  logic mem [0:2047];
  int   errors = 0;
  int   checks = 0;

  adat_sample_reader #(.CIRC_BUF_BITS(CB)) dut (
    .clk_i                 (clk_i),
    .reset_ni              (reset_ni),
    .has_sync_i            (has_sync_i),
    .last_good_frame_idx_i (last_good_frame_idx_i),
    .ram_read_addr_o       (ram_read_addr_o),
    .ram_read_data_i       (ram_read_data_i),
    .sample_data_o         (sample_data_o),
    .sample_channel_o      (sample_channel_o),
    .sample_last_o         (sample_last_o),
    .sample_valid_o        (sample_valid_o),
    .sample_ready_i        (sample_ready_i),
    .dropped_frames_o      (dropped_frames_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) ram_read_data_i <= mem[ram_read_addr_o];

  function automatic logic [23:0] samp(int slot, int ch);
    if (slot == 2 && ch == 0) return 24'hA5A5A5;
    if (slot == 2 && ch == 7) return 24'h000001;
    return {8'(slot * 16 + ch + 1), 8'(8'hC3 ^ (slot * 8 + ch)), 8'(8'h5A + ch * 3)};
  endfunction

  task automatic fill_mem();
    logic [23:0] s;
    for (int slot = 0; slot < 8; slot++)
      for (int ch = 0; ch < 8; ch++) begin
        s = samp(slot, ch);
        for (int b = 0; b < 32; b++)
          mem[slot * 256 + ch * 32 + b] = (b < 24) ? s[23 - b] : 1'b0;
      end
  endtask

  task automatic push_frame(int slot);
    exp_t e;
    for (int ch = 0; ch < 8; ch++) begin
      e.data = {samp(slot, ch), 8'h00};
      e.ch   = 3'(ch);
      e.last = (ch == 7);
      sb.push_back(e);
    end
  endtask

  // Returns at #1 after the edge that completed the handshake.
  task automatic wait_transfer(input int budget, output bit got, output exp_t obs);
    got = 1'b0;
    obs = '0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk_i);
      if (sample_valid_o === 1'b1 && sample_ready_i === 1'b1) begin
        got = 1'b1;
        obs = {sample_data_o, sample_channel_o, sample_last_o};
      end
    end
    if (got) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk_i);
      if (sample_valid_o === 1'b1) got = 1'b1;
    end
  endtask

  task automatic apply_reset();
    reset_ni              = 1'b0;
    has_sync_i            = 1'b0;
    sample_ready_i        = 1'b0;
    last_good_frame_idx_i = '0;
    sb.delete();
    repeat (3) @(posedge clk_i);
    #1 reset_ni = 1'b1;
  endtask

  task automatic test_reset();
    bit quiet;
    reset_ni = 1'b0;
    has_sync_i = 1'b0;
    sample_ready_i = 1'b1;
    last_good_frame_idx_i = 3'd2;
    #1;
    checks++;
    if ({sample_valid_o, sample_data_o, sample_channel_o, sample_last_o, dropped_frames_o, ram_read_addr_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h ch=%0d last=%b drops=%0d addr=%h, all must be 0",
               sample_valid_o, sample_data_o, sample_channel_o, sample_last_o, dropped_frames_o, ram_read_addr_o);
    end
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    quiet = 1'b1;
    repeat (50) begin
      @(negedge clk_i);
      if (sample_valid_o !== 1'b0 || ram_read_addr_o !== '0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL no_sync_quiet: activity=1 without has_sync_i, required activity=0");
    end
    sample_ready_i = 1'b0;
  endtask

  task automatic test_basic();
    bit found, seen, quiet;
    int lat;
    exp_t obs, e;
    push_frame(2);
    @(posedge clk_i);
    #1 has_sync_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_i);
      if (ram_read_addr_o === 11'h200) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL first_addr: address 200 not seen, required within 100 cycles");
    end
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk_i);
      lat++;
      if (sample_valid_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || lat != 25) begin
      errors++;
      $display("FAIL latency: got %0d cycles (valid seen=%0b), required 25", lat, seen);
    end
    @(posedge clk_i);
    #1 sample_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_transfer(200, found, obs);
      e = sb.pop_front();
      checks++;
      if (!found || obs !== e) begin
        errors++;
        $display("FAIL basic_sample%0d: got data=%h ch=%0d last=%b (seen=%0b), required data=%h ch=%0d last=%b",
                 k, obs.data, obs.ch, obs.last, found, e.data, e.ch, e.last);
      end
    end
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk_i);
      if (sample_valid_o !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet || dropped_frames_o !== 16'd0) begin
      errors++;
      $display("FAIL basic_idle_after_frame: quiet=%0b drops=%0d, required quiet=1 drops=0", quiet, dropped_frames_o);
    end
  endtask

  task automatic test_stall();
    bit got, stable;
    exp_t obs, e;
    logic [31:0] d0;
    logic [2:0]  c0;
    sample_ready_i = 1'b0;
    push_frame(3);
    last_good_frame_idx_i = 3'd3;
    for (int k = 0; k < 8; k++) begin
      wait_valid(200, got);
      if (k == 3 && got) begin
        d0 = sample_data_o;
        c0 = sample_channel_o;
        stable = 1'b1;
        repeat (40) begin
          @(negedge clk_i);
          if (sample_valid_o !== 1'b1 || sample_data_o !== d0 || sample_channel_o !== c0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
          errors++;
          $display("FAIL stall_hold: output changed during stall (ch=%0d data=%h), required held at ch=%0d data=%h",
                   sample_channel_o, sample_data_o, c0, d0);
        end
      end
      @(posedge clk_i);
      #1 sample_ready_i = 1'b1;
      wait_transfer(5, got, obs);
      sample_ready_i = 1'b0;
      e = sb.pop_front();
      checks++;
      if (!got || obs !== e) begin
        errors++;
        $display("FAIL stall_sample%0d: got data=%h ch=%0d last=%b (seen=%0b), required data=%h ch=%0d last=%b",
                 k, obs.data, obs.ch, obs.last, got, e.data, e.ch, e.last);
      end
      if (k == 3) begin
        checks++;
        if (sample_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL stall_single_transfer: valid=%b after handshake, required 0", sample_valid_o);
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit got, quiet;
    exp_t obs, e;
    int slots[3] = '{7, 0, 1};
    apply_reset();
    sample_ready_i = 1'b1;
    for (int f = 0; f < 3; f++) begin
      last_good_frame_idx_i = 3'(slots[f]);
      has_sync_i = 1'b1;
      push_frame(slots[f]);
      for (int k = 0; k < 8; k++) begin
        wait_transfer(200, got, obs);
        e = sb.pop_front();
        checks++;
        if (!got || obs !== e) begin
          errors++;
          $display("FAIL wrap_slot%0d_sample%0d: got data=%h ch=%0d last=%b (seen=%0b), required data=%h ch=%0d last=%b",
                   slots[f], k, obs.data, obs.ch, obs.last, got, e.data, e.ch, e.last);
        end
      end
      quiet = 1'b1;
      repeat (30) begin
        @(negedge clk_i);
        if (sample_valid_o !== 1'b0) quiet = 1'b0;
      end
      checks++;
      if (!quiet) begin
        errors++;
        $display("FAIL wrap_wait_slot%0d: sample produced with no new frame, required none", slots[f]);
      end
    end
    checks++;
    if (dropped_frames_o !== 16'd0) begin
      errors++;
      $display("FAIL wrap_drops: got %0d, required 0", dropped_frames_o);
    end
  endtask

  task automatic test_overrun();
    bit got;
    exp_t obs, e;
    apply_reset();
    sample_ready_i = 1'b1;
    last_good_frame_idx_i = 3'd7;
    has_sync_i = 1'b1;
    push_frame(7);
    push_frame(6);
    for (int k = 0; k < 16; k++) begin
      if (k == 8) begin
        checks++;
        if (dropped_frames_o !== 16'd0) begin
          errors++;
          $display("FAIL overrun_pre_drops: got %0d, required 0", dropped_frames_o);
        end
        last_good_frame_idx_i = 3'd6;
      end
      wait_transfer(200, got, obs);
      e = sb.pop_front();
      checks++;
      if (!got || obs !== e) begin
        errors++;
        $display("FAIL overrun_sample%0d: got data=%h ch=%0d last=%b (seen=%0b), required data=%h ch=%0d last=%b",
                 k, obs.data, obs.ch, obs.last, got, e.data, e.ch, e.last);
      end
    end
    checks++;
    if (dropped_frames_o !== 16'd6) begin
      errors++;
      $display("FAIL overrun_drops: got %0d, required 6", dropped_frames_o);
    end
  endtask

  task automatic test_sync_drop();
    bit got, quiet;
    exp_t obs, e;
    apply_reset();
    sample_ready_i = 1'b1;
    last_good_frame_idx_i = 3'd2;
    has_sync_i = 1'b1;
    push_frame(2);
    for (int k = 0; k < 8; k++) begin
      wait_transfer(200, got, obs);
      if (k == 3) has_sync_i = 1'b0;
      e = sb.pop_front();
      checks++;
      if (!got || obs !== e) begin
        errors++;
        $display("FAIL syncdrop_sample%0d: got data=%h ch=%0d last=%b (seen=%0b), required data=%h ch=%0d last=%b",
                 k, obs.data, obs.ch, obs.last, got, e.data, e.ch, e.last);
      end
    end
    quiet = 1'b1;
    repeat (60) begin
      @(negedge clk_i);
      if (sample_valid_o !== 1'b0 || ram_read_addr_o !== '0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL syncdrop_quiet: reads or samples continued without sync, required none");
    end
    has_sync_i = 1'b1;
    push_frame(2);
    for (int k = 0; k < 8; k++) begin
      wait_transfer(200, got, obs);
      e = sb.pop_front();
      checks++;
      if (!got || obs !== e) begin
        errors++;
        $display("FAIL syncdrop_resume%0d: got data=%h ch=%0d last=%b (seen=%0b), required data=%h ch=%0d last=%b",
                 k, obs.data, obs.ch, obs.last, got, e.data, e.ch, e.last);
      end
    end
  endtask

  task automatic test_reset_midhandshake();
    bit got;
    exp_t obs, e;
    apply_reset();
    last_good_frame_idx_i = 3'd2;
    has_sync_i = 1'b1;
    wait_valid(200, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL midreset_valid: valid=0, required 1 before reset");
    end
    @(posedge clk_i);
    #3 reset_ni = 1'b0;
    #1;
    checks++;
    if ({sample_valid_o, sample_data_o, sample_channel_o, sample_last_o, dropped_frames_o, ram_read_addr_o} !== '0) begin
      errors++;
      $display("FAIL midreset_async: valid=%b data=%h ch=%0d last=%b drops=%0d addr=%h, all must be 0",
               sample_valid_o, sample_data_o, sample_channel_o, sample_last_o, dropped_frames_o, ram_read_addr_o);
    end
    sb.delete();
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
    sample_ready_i = 1'b1;
    push_frame(2);
    for (int k = 0; k < 8; k++) begin
      wait_transfer(200, got, obs);
      e = sb.pop_front();
      checks++;
      if (!got || obs !== e) begin
        errors++;
        $display("FAIL midreset_restart%0d: got data=%h ch=%0d last=%b (seen=%0b), required data=%h ch=%0d last=%b",
                 k, obs.data, obs.ch, obs.last, got, e.data, e.ch, e.last);
      end
    end
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_overrun();
    test_sync_drop();
    test_reset_midhandshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
